// File: rtl/runner_game_core.sv
// runner_game_core: game-state engine for the side-scrolling runner.
// Owns the jump physics, N_OBS scrolling obstacles, the difficulty ramp,
// collision detection, score and the IDLE/RUN/PAUSE/OVER state machine.
// All slower time bases arrive as single-cycle enables on the one clock.
//
// Ports:
//   clk          system clock
//   clr_n        synchronous active-low reset
//   tick_01ms    0.1 ms enable (scroll divider)
//   tick_5ms     5 ms enable (jump physics)
//   tick_100ms   100 ms enable (score, ramp, animation)
//   start        level, start / restart
//   jump         level, jump button (rising edge is latched)
//   pause        level, pause while high
//   obs_x        obstacle left x, obstacle i at [i*XW +: XW]
//   player_y     player top y
//   anim_frame   running sprite select
//   state        0=IDLE 1=RUN 2=PAUSE 3=OVER
//   game_over    high in OVER
//   score        elapsed 100 ms ticks, saturating
//   speed_div    current scroll divider
//
// Optional feature: define RUNNER_DOUBLE_JUMP_EN to allow one extra jump
// per flight while airborne.
module runner_game_core #(
   parameter int N_OBS      = 2,
   parameter int XW         = 11,
   parameter int PLAYER_X   = 120,
   parameter int PLAYER_W   = 60,
   parameter int PLAYER_H   = 60,
   parameter int Y_GROUND   = 270,
   parameter int Y_OBS      = 268,
   parameter int OBS_W      = 70,
   parameter int MARGIN     = 10,
   parameter int SPAN       = 1200,
   parameter int V0         = 82,
   parameter int G          = 1,
   parameter int FRAC       = 5,
   parameter int DIFF_INIT  = 60,
   parameter int DIFF_MIN   = 20,
   parameter int DIFF_STEP  = 4,
   parameter int RAMP_TICKS = 50
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                tick_01ms,
   input  logic                tick_5ms,
   input  logic                tick_100ms,
   input  logic                start,
   input  logic                jump,
   input  logic                pause,
   output logic [N_OBS*XW-1:0] obs_x,
   output logic [XW-1:0]       player_y,
   output logic                anim_frame,
   output logic [1:0]          state,
   output logic                game_over,
   output logic [15:0]         score,
   output logic [7:0]          speed_div
);

   localparam int HW = XW + FRAC;
   localparam logic signed [9:0] V0_S = 10'(V0);
   localparam logic signed [9:0] G_S  = 10'(G);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3} state_t;
   state_t state_q, state_d;

   logic [HW-1:0]       h_q, h_d;
   logic signed [9:0]   v_q, v_d;
   logic signed [HW+1:0] hv_sum;
   logic [XW-1:0]       obs_q [N_OBS];
   logic [XW-1:0]       obs_d [N_OBS];
   logic [XW-1:0]       player_y_q, player_y_d;
   logic                anim_q, anim_d;
   logic [15:0]         score_q, score_d;
   logic [7:0]          div_q, div_d;
   logic [7:0]          div_cnt_q, div_cnt_d;
   logic [15:0]         ramp_cnt_q, ramp_cnt_d;
   logic                jump_prev_q, latch_q, latch_d;
   logic                on_ground, collide, reload, step;
   logic [N_OBS-1:0]    hit;
`ifdef RUNNER_DOUBLE_JUMP_EN
   logic                dj_used_q, dj_used_d;
`endif

   function automatic logic [15:0] sat_inc16(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   // Floor-clamped decrement; compare first so a small divider never wraps.
   function automatic logic [7:0] ramp_div(input logic [7:0] d);
      if (d <= 8'(DIFF_MIN + DIFF_STEP)) return 8'(DIFF_MIN);
      else return d - 8'(DIFF_STEP);
   endfunction

   assign on_ground = (h_q == '0) && (v_q == '0);
   assign hv_sum    = signed'({2'b00, h_q}) + signed'({{(HW-8){v_q[9]}}, v_q});
   assign reload    = !clr_n || (state_q == S_OVER && start);

   // Collision boxes, widened by one bit so the sums never wrap.
   always_comb begin
      for (int i = 0; i < N_OBS; i++) begin
         hit[i] = ((XW+1)'(PLAYER_X + MARGIN) < {1'b0, obs_q[i]} + (XW+1)'(OBS_W - MARGIN)) &&
                  ({1'b0, obs_q[i]} + (XW+1)'(MARGIN) < (XW+1)'(PLAYER_X + PLAYER_W - MARGIN)) &&
                  ({1'b0, player_y_q} + (XW+1)'(PLAYER_H) > (XW+1)'(Y_OBS + MARGIN));
      end
   end
   assign collide = |hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (collide) state_d = S_OVER;
                  else if (pause) state_d = S_PAUSE;
         S_PAUSE: if (!pause) state_d = S_RUN;
         S_OVER:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      h_d        = h_q;
      v_d        = v_q;
      player_y_d = player_y_q;
      anim_d     = anim_q;
      score_d    = score_q;
      div_d      = div_q;
      div_cnt_d  = div_cnt_q;
      ramp_cnt_d = ramp_cnt_q;
      obs_d      = obs_q;
      latch_d    = 1'b0;
      step       = 1'b0;
`ifdef RUNNER_DOUBLE_JUMP_EN
      dj_used_d  = dj_used_q;
`endif
      if (state_q == S_RUN) begin
         // A latched edge survives only until the next physics tick.
         latch_d = (latch_q && !tick_5ms) || (jump && !jump_prev_q);

         if (tick_5ms) begin
            if (on_ground) begin
               if (latch_q) v_d = V0_S;
            end
`ifdef RUNNER_DOUBLE_JUMP_EN
            else if (latch_q && !dj_used_q) begin
               v_d       = V0_S;
               dj_used_d = 1'b1;
            end
`endif
            else if (hv_sum[HW+1] || hv_sum == '0) begin
               h_d = '0;
               v_d = '0;
`ifdef RUNNER_DOUBLE_JUMP_EN
               dj_used_d = 1'b0;
`endif
            end else begin
               h_d = hv_sum[HW-1:0];
               v_d = v_q - G_S;
            end
         end
         player_y_d = XW'(Y_GROUND) - XW'(h_d >> FRAC);

         if (tick_01ms) begin
            // >= keeps the divider sane if a ramp shrinks it below the count.
            if (div_cnt_q >= div_q - 8'd1) begin
               div_cnt_d = '0;
               step      = 1'b1;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         if (step) begin
            for (int i = 0; i < N_OBS; i++)
               obs_d[i] = (obs_q[i] == '0) ? XW'(SPAN) : obs_q[i] - XW'(1);
         end

         if (tick_100ms) begin
            score_d = sat_inc16(score_q);
            if (ramp_cnt_q == 16'(RAMP_TICKS - 1)) begin
               ramp_cnt_d = '0;
               div_d      = ramp_div(div_q);
            end else begin
               ramp_cnt_d = ramp_cnt_q + 16'd1;
            end
         end

         if (!on_ground) anim_d = 1'b1;
         else if (tick_100ms) anim_d = !anim_q;
      end
      if (state_d != S_RUN) latch_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!clr_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reload) begin
         h_q         <= '0;
         v_q         <= '0;
         player_y_q  <= XW'(Y_GROUND);
         anim_q      <= 1'b0;
         score_q     <= '0;
         div_q       <= 8'(DIFF_INIT);
         div_cnt_q   <= '0;
         ramp_cnt_q  <= '0;
         jump_prev_q <= 1'b0;
         latch_q     <= 1'b0;
         for (int i = 0; i < N_OBS; i++) obs_q[i] <= XW'(SPAN - i * (SPAN / N_OBS));
`ifdef RUNNER_DOUBLE_JUMP_EN
         dj_used_q   <= 1'b0;
`endif
      end else begin
         h_q         <= h_d;
         v_q         <= v_d;
         player_y_q  <= player_y_d;
         anim_q      <= anim_d;
         score_q     <= score_d;
         div_q       <= div_d;
         div_cnt_q   <= div_cnt_d;
         ramp_cnt_q  <= ramp_cnt_d;
         jump_prev_q <= jump;
         latch_q     <= latch_d;
         obs_q       <= obs_d;
`ifdef RUNNER_DOUBLE_JUMP_EN
         dj_used_q   <= dj_used_d;
`endif
      end
   end

   for (genvar g = 0; g < N_OBS; g++) begin : g_obs
      assign obs_x[g*XW +: XW] = obs_q[g];
   end

   assign player_y   = player_y_q;
   assign anim_frame = anim_q;
   assign state      = state_q;
   assign game_over  = (state_q == S_OVER);
   assign score      = score_q;
   assign speed_div  = div_q;

endmodule

// File: tb/tb_runner_game_core.sv
module tb_runner_game_core;

   logic        clk = 1'b0;
   logic        clr_n, tick_01ms, tick_5ms, tick_100ms, start, jump, pause;
   logic [21:0] a_obs;
   logic [10:0] a_y, b_obs, b_y;
   logic        a_anim, a_over, b_anim, b_over;
   logic [1:0]  a_state, b_state;
   logic [15:0] a_score, b_score;
   logic [7:0]  a_div, b_div;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   runner_game_core dut (
      .clk(clk), .clr_n(clr_n), .tick_01ms(tick_01ms), .tick_5ms(tick_5ms),
      .tick_100ms(tick_100ms), .start(start), .jump(jump), .pause(pause),
      .obs_x(a_obs), .player_y(a_y), .anim_frame(a_anim), .state(a_state),
      .game_over(a_over), .score(a_score), .speed_div(a_div)
   );

   // Single obstacle far left of the player: it wraps through 0 without colliding.
   runner_game_core #(.N_OBS(1), .SPAN(100), .PLAYER_X(500), .DIFF_INIT(1), .DIFF_MIN(1)) dut_b (
      .clk(clk), .clr_n(clr_n), .tick_01ms(tick_01ms), .tick_5ms(tick_5ms),
      .tick_100ms(tick_100ms), .start(start), .jump(jump), .pause(pause),
      .obs_x(b_obs), .player_y(b_y), .anim_frame(b_anim), .state(b_state),
      .game_over(b_over), .score(b_score), .speed_div(b_div)
   );

   task automatic cycle(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      tick_01ms = 0; tick_5ms = 0; tick_100ms = 0; start = 0; jump = 0; pause = 0;
   endtask

   task automatic reset_and_start();
      idle_inputs();
      clr_n = 0;
      cycle(2);
      clr_n = 1;
      start = 1;
      cycle(1);
      start = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      start = 1;
      clr_n = 0;
      cycle(2);
      n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", a_state); end
      n_checks++; if (a_y !== 11'd270) begin n_fail++; $display("FAIL reset_y got %0d want 270", a_y); end
      n_checks++; if (a_obs !== {11'd600, 11'd1200}) begin n_fail++; $display("FAIL reset_obs got %0d,%0d want 1200,600", a_obs[10:0], a_obs[21:11]); end
      n_checks++; if (a_div !== 8'd60) begin n_fail++; $display("FAIL reset_div got %0d want 60", a_div); end
      n_checks++; if (a_score !== 16'd0 || a_anim !== 1'b0 || a_over !== 1'b0) begin n_fail++; $display("FAIL reset_misc score %0d anim %0b over %0b want 0 0 0", a_score, a_anim, a_over); end
      n_checks++; if (b_obs !== 11'd100) begin n_fail++; $display("FAIL reset_b_obs got %0d want 100", b_obs); end
      clr_n = 1;
      start = 0;
   endtask

   task automatic test_jump();
      reset_and_start();
      n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL jump_run_state got %0d want 1", a_state); end
      jump = 1; cycle(1); jump = 0; cycle(1);
      tick_5ms = 1; cycle(1); tick_5ms = 0;  // launch tick
      n_checks++; if (a_y !== 11'd270) begin n_fail++; $display("FAIL jump_launch_y got %0d want 270", a_y); end
      for (int k = 1; k <= 165; k++) begin
         if (k == 90) begin
            jump = 1; cycle(1); jump = 0; cycle(1);
         end
         tick_5ms = 1; cycle(1); tick_5ms = 0;
         if (k == 82) begin
            n_checks++; if (a_y !== 11'd164) begin n_fail++; $display("FAIL jump_peak_y got %0d want 164", a_y); end
            n_checks++; if (a_anim !== 1'b1) begin n_fail++; $display("FAIL jump_anim got %0b want 1", a_anim); end
         end
         if (k == 164) begin
            n_checks++; if (a_y !== 11'd268) begin n_fail++; $display("FAIL jump_prelanding_y got %0d want 268", a_y); end
         end
         if (k == 165) begin
            n_checks++; if (a_y !== 11'd270) begin n_fail++; $display("FAIL jump_landed_y got %0d want 270", a_y); end
         end
      end
   endtask

   task automatic test_scroll();
      reset_and_start();
      tick_01ms = 1;
      cycle(100);
      n_checks++; if (b_obs !== 11'd0) begin n_fail++; $display("FAIL scroll_b_zero got %0d want 0", b_obs); end
      n_checks++; if (a_obs !== {11'd599, 11'd1199}) begin n_fail++; $display("FAIL scroll_100 got %0d,%0d want 1199,599", a_obs[10:0], a_obs[21:11]); end
      cycle(1);
      n_checks++; if (b_obs !== 11'd100) begin n_fail++; $display("FAIL scroll_b_reload got %0d want 100", b_obs); end
      cycle(19);
      tick_01ms = 0;
      n_checks++; if (a_obs !== {11'd598, 11'd1198}) begin n_fail++; $display("FAIL scroll_120 got %0d,%0d want 1198,598", a_obs[10:0], a_obs[21:11]); end
      n_checks++; if (b_obs !== 11'd81) begin n_fail++; $display("FAIL scroll_b_120 got %0d want 81", b_obs); end
   endtask

   task automatic test_ramp();
      reset_and_start();
      tick_100ms = 1;
      cycle(1);
      n_checks++; if (a_score !== 16'd1 || a_anim !== 1'b1) begin n_fail++; $display("FAIL ramp_first score %0d anim %0b want 1 1", a_score, a_anim); end
      cycle(49);
      n_checks++; if (a_div !== 8'd56 || a_score !== 16'd50) begin n_fail++; $display("FAIL ramp_50 div %0d score %0d want 56 50", a_div, a_score); end
      n_checks++; if (a_anim !== 1'b0) begin n_fail++; $display("FAIL ramp_anim got %0b want 0", a_anim); end
      cycle(550);
      tick_100ms = 0;
      n_checks++; if (a_div !== 8'd20 || a_score !== 16'd600) begin n_fail++; $display("FAIL ramp_600 div %0d score %0d want 20 600", a_div, a_score); end
      n_checks++; if (b_div !== 8'd1) begin n_fail++; $display("FAIL ramp_b_floor got %0d want 1", b_div); end
   endtask

   // Continues from test_ramp: RUN, speed_div=20, score=600.
   task automatic test_collision();
      bit          seen = 0;
      logic [21:0] obs_hold;
      logic        anim_hold;
      tick_01ms = 1;
      for (int i = 0; i < 10000 && !seen; i++) begin
         cycle(1);
         if (a_state == 2'd3) seen = 1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL coll_reach got state %0d want 3", a_state); end
      n_checks++; if (a_obs !== {11'd159, 11'd759}) begin n_fail++; $display("FAIL coll_obs got %0d,%0d want 759,159", a_obs[10:0], a_obs[21:11]); end
      n_checks++; if (a_over !== 1'b1) begin n_fail++; $display("FAIL coll_over got %0b want 1", a_over); end
      obs_hold = a_obs;
      anim_hold = a_anim;
      tick_5ms = 1; tick_100ms = 1; jump = 1;
      cycle(300);
      idle_inputs();
      n_checks++; if (a_obs !== obs_hold || a_score !== 16'd600 || a_div !== 8'd20 || a_y !== 11'd270 || a_anim !== anim_hold || a_state !== 2'd3) begin
         n_fail++; $display("FAIL coll_freeze obs %0d,%0d score %0d div %0d y %0d state %0d want 759,159 600 20 270 3", a_obs[10:0], a_obs[21:11], a_score, a_div, a_y, a_state);
      end
      start = 1; cycle(1); start = 0;
      n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL restart_state got %0d want 1", a_state); end
      n_checks++; if (a_obs !== {11'd600, 11'd1200} || a_score !== 16'd0 || a_div !== 8'd60) begin
         n_fail++; $display("FAIL restart_vals obs %0d,%0d score %0d div %0d want 1200,600 0 60", a_obs[10:0], a_obs[21:11], a_score, a_div);
      end
   endtask

   task automatic test_pause();
      reset_and_start();
      tick_01ms = 1; cycle(60); tick_01ms = 0;
      pause = 1; cycle(1);
      n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL pause_state got %0d want 2", a_state); end
      tick_01ms = 1; tick_5ms = 1; tick_100ms = 1;
      for (int i = 0; i < 1000; i++) begin
         jump = i[0];
         cycle(1);
      end
      idle_inputs(); pause = 1;
      n_checks++; if (a_obs !== {11'd599, 11'd1199} || a_score !== 16'd0 || a_div !== 8'd60 || a_y !== 11'd270) begin
         n_fail++; $display("FAIL pause_hold obs %0d,%0d score %0d div %0d y %0d want 1199,599 0 60 270", a_obs[10:0], a_obs[21:11], a_score, a_div, a_y);
      end
      pause = 0; cycle(1);
      n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL pause_release got %0d want 1", a_state); end
      tick_01ms = 1; cycle(60); tick_01ms = 0;
      tick_100ms = 1; cycle(1); tick_100ms = 0;
      n_checks++; if (a_obs !== {11'd598, 11'd1198} || a_score !== 16'd1) begin
         n_fail++; $display("FAIL pause_resume obs %0d,%0d score %0d want 1198,598 1", a_obs[10:0], a_obs[21:11], a_score);
      end
   endtask

   initial begin
      clr_n = 0;
      idle_inputs();
      test_reset();
      test_jump();
      test_scroll();
      test_ramp();
      test_collision();
      test_pause();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
